// File: rtl/mc_controller.sv
// Multicycle ARM-subset controller: main FSM, ALU decode, condition check
// and the registered NZCV flags.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   Cond, Op, Funct       : instruction fields Instr[31:28], [27:26], [25:20]
//   ALUFlags              : NZCV produced by the ALU this cycle
//   PCWrite/IRWrite/RegWrite/MemWrite : write enables (forced 0 in reset)
//   AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl : datapath selects
//   Flags                 : registered NZCV
//   State                 : current FSM state code
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic [3:0] Flags,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB  = 4'd4,
    MEMWR  = 4'd5, EXECR  = 4'd6, EXECI  = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9
  } state_t;

  state_t     r_state, w_next;
  logic [3:0] r_flags;
  logic       w_condex, w_n, w_z, w_c, w_v;
  logic [3:0] w_cmd;
  logic       w_is_cmp, w_cmd_ok;
  logic [1:0] w_aluctl;
  logic       w_pcw, w_irw, w_rw, w_mw, w_flag_ld;

  assign {w_n, w_z, w_c, w_v} = r_flags;
  assign w_cmd    = Funct[4:1];
  assign w_is_cmp = (w_cmd == 4'b1010);

  // Condition check against the registered flags.
  always_comb begin
    w_condex = 1'b0;
    unique case (Cond)
      4'b0000: w_condex = w_z;
      4'b0001: w_condex = ~w_z;
      4'b0010: w_condex = w_c;
      4'b0011: w_condex = ~w_c;
      4'b0100: w_condex = w_n;
      4'b0101: w_condex = ~w_n;
      4'b0110: w_condex = w_v;
      4'b0111: w_condex = ~w_v;
      4'b1000: w_condex = w_c & ~w_z;
      4'b1001: w_condex = ~w_c | w_z;
      4'b1010: w_condex = (w_n == w_v);
      4'b1011: w_condex = (w_n != w_v);
      4'b1100: w_condex = ~w_z & (w_n == w_v);
      4'b1101: w_condex = w_z | (w_n != w_v);
      4'b1110: w_condex = 1'b1;
      default: w_condex = 1'b0;
    endcase
  end

  // ALU decode; unknown commands default to ADD and never write back.
  always_comb begin
    w_aluctl = 2'b00;
    w_cmd_ok = 1'b1;
    unique case (w_cmd)
      4'b0100: w_aluctl = 2'b00;
      4'b0010: w_aluctl = 2'b01;
      4'b0000: w_aluctl = 2'b10;
      4'b1100: w_aluctl = 2'b11;
      4'b1010: w_aluctl = 2'b01;
      default: begin w_aluctl = 2'b00; w_cmd_ok = 1'b0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
      r_flags <= 4'b0000;
    end else begin
      r_state <= w_next;
      if (w_flag_ld) r_flags <= ALUFlags;
    end
  end

  always_comb begin
    w_next     = FETCH;
    w_pcw      = 1'b0;
    w_irw      = 1'b0;
    w_rw       = 1'b0;
    w_mw       = 1'b0;
    w_flag_ld  = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 2'b00;
    unique case (r_state)
      FETCH: begin
        w_next = DECODE;
        w_irw = 1'b1; w_pcw = 1'b1;
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      DECODE: begin
        unique case (Op)
          2'b00:   w_next = Funct[5] ? EXECI : EXECR;
          2'b01:   w_next = MEMADR;
          2'b10:   w_next = BRANCH;
          default: w_next = FETCH;
        endcase
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      MEMADR: begin
        w_next = Funct[0] ? MEMRD : MEMWR;
        ALUSrcB = 2'b01;
      end
      MEMRD:  begin w_next = MEMWB; AdrSrc = 1'b1; end
      MEMWB:  begin ResultSrc = 2'b01; w_rw = w_condex; end
      MEMWR:  begin AdrSrc = 1'b1; w_mw = w_condex; end
      EXECR, EXECI: begin
        w_next     = ALUWB;
        ALUSrcB    = (r_state == EXECI) ? 2'b01 : 2'b00;
        ALUControl = w_aluctl;
        w_flag_ld  = w_condex & (Funct[0] | w_is_cmp);
      end
      ALUWB:  w_rw = w_condex & w_cmd_ok & ~w_is_cmp;
      BRANCH: begin
        ALUSrcB = 2'b01; ResultSrc = 2'b10;
        w_pcw = w_condex;
      end
      default: w_next = FETCH;
    endcase
  end

  // Write enables are held off for the whole reset cycle.
  assign PCWrite  = w_pcw & ~reset;
  assign IRWrite  = w_irw & ~reset;
  assign RegWrite = w_rw  & ~reset;
  assign MemWrite = w_mw  & ~reset;

  assign ImmSrc = Op;
  assign RegSrc = {(Op == 2'b01) & ~Funct[0], (Op == 2'b10)};
  assign Flags  = r_flags;
  assign State  = r_state;

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] ALUFlags;
  logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
  logic [3:0] Flags, State;

  int n_chk = 0;
  int n_err = 0;

  mc_controller dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
    .Flags(Flags), .State(State)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f);
    Cond = c; Op = o; Funct = f;
    #1;
  endtask

  initial begin
    reset = 1'b1; ALUFlags = 4'b0000;
    instr(4'b1110, 2'b00, 6'b001000);   // ADD reg
    tick();
    chk("rst_state", {4'h0, State}, 8'h0);
    chk("rst_flags", {4'h0, Flags}, 8'h0);
    chk("rst_pcw", {7'h0, PCWrite}, 8'h0);
    chk("rst_irw", {7'h0, IRWrite}, 8'h0);
    reset = 1'b0; #1;
    // ADD: 0,1,6,8,0
    chk("add_f_pcw", {7'h0, PCWrite}, 8'h1);
    chk("add_f_irw", {7'h0, IRWrite}, 8'h1);
    chk("add_f_srcb", {6'h0, ALUSrcB}, 8'h2);
    chk("add_f_res", {6'h0, ResultSrc}, 8'h2);
    tick(); chk("add_s1", {4'h0, State}, 8'h1);
    chk("add_d_rw", {7'h0, RegWrite}, 8'h0);
    chk("add_d_pcw", {7'h0, PCWrite}, 8'h0);
    tick(); chk("add_s6", {4'h0, State}, 8'h6);
    chk("add_e_alu", {6'h0, ALUControl}, 8'h0);
    chk("add_e_rw", {7'h0, RegWrite}, 8'h0);
    chk("add_e_srcb", {6'h0, ALUSrcB}, 8'h0);
    tick(); chk("add_s8", {4'h0, State}, 8'h8);
    chk("add_wb_rw", {7'h0, RegWrite}, 8'h1);
    tick(); chk("add_s0", {4'h0, State}, 8'h0);
    chk("add_flags", {4'h0, Flags}, 8'h0);

    // LDR: 0,1,2,3,4,0
    instr(4'b1110, 2'b01, 6'b011001);
    tick(); chk("ldr_s1", {4'h0, State}, 8'h1);
    tick(); chk("ldr_s2", {4'h0, State}, 8'h2);
    chk("ldr_a_srcb", {6'h0, ALUSrcB}, 8'h1);
    chk("ldr_imm", {6'h0, ImmSrc}, 8'h1);
    tick(); chk("ldr_s3", {4'h0, State}, 8'h3);
    chk("ldr_adr", {7'h0, AdrSrc}, 8'h1);
    tick(); chk("ldr_s4", {4'h0, State}, 8'h4);
    chk("ldr_wb_rw", {7'h0, RegWrite}, 8'h1);
    chk("ldr_wb_res", {6'h0, ResultSrc}, 8'h1);
    tick(); chk("ldr_s0", {4'h0, State}, 8'h0);

    // STR: 0,1,2,5,0
    instr(4'b1110, 2'b01, 6'b011000);
    chk("str_regsrc", {6'h0, RegSrc}, 8'h2);
    tick(); chk("str_s1", {4'h0, State}, 8'h1);
    chk("str_d_mw", {7'h0, MemWrite}, 8'h0);
    tick(); chk("str_s2", {4'h0, State}, 8'h2);
    tick(); chk("str_s5", {4'h0, State}, 8'h5);
    chk("str_mw", {7'h0, MemWrite}, 8'h1);
    chk("str_rw", {7'h0, RegWrite}, 8'h0);
    tick(); chk("str_s0", {4'h0, State}, 8'h0);
    chk("str_f_mw", {7'h0, MemWrite}, 8'h0);

    // CMP with ALUFlags=0100 (Z)
    instr(4'b1110, 2'b00, 6'b010101);
    ALUFlags = 4'b0100;
    tick(); tick(); chk("cmp_s6", {4'h0, State}, 8'h6);
    chk("cmp_alu", {6'h0, ALUControl}, 8'h1);
    tick(); chk("cmp_s8", {4'h0, State}, 8'h8);
    chk("cmp_flags", {4'h0, Flags}, 8'h4);
    chk("cmp_rw", {7'h0, RegWrite}, 8'h0);
    ALUFlags = 4'b0000;
    tick();

    // BEQ taken (Z=1)
    instr(4'b0000, 2'b10, 6'b000000);
    chk("beq_regsrc", {6'h0, RegSrc}, 8'h1);
    tick(); tick(); chk("beq_s9", {4'h0, State}, 8'h9);
    chk("beq_pcw", {7'h0, PCWrite}, 8'h1);
    chk("beq_srcb", {6'h0, ALUSrcB}, 8'h1);
    chk("beq_res", {6'h0, ResultSrc}, 8'h2);
    tick(); chk("beq_s0", {4'h0, State}, 8'h0);

    // BNE not taken
    instr(4'b0001, 2'b10, 6'b000000);
    tick(); tick(); chk("bne_s9", {4'h0, State}, 8'h9);
    chk("bne_pcw", {7'h0, PCWrite}, 8'h0);
    tick();

    // SUBSNE while Z=1: no writeback, flags held
    instr(4'b0001, 2'b00, 6'b000101);
    ALUFlags = 4'b1111;
    tick(); tick(); chk("subs_alu", {6'h0, ALUControl}, 8'h1);
    tick(); chk("subs_s8", {4'h0, State}, 8'h8);
    chk("subs_rw", {7'h0, RegWrite}, 8'h0);
    chk("subs_flags", {4'h0, Flags}, 8'h4);
    ALUFlags = 4'b0000;
    tick();

    // ORR immediate: EXECI
    instr(4'b1110, 2'b00, 6'b111000);
    tick(); tick(); chk("orr_s7", {4'h0, State}, 8'h7);
    chk("orr_alu", {6'h0, ALUControl}, 8'h3);
    chk("orr_srcb", {6'h0, ALUSrcB}, 8'h1);
    tick(); chk("orr_rw", {7'h0, RegWrite}, 8'h1);
    chk("orr_wb_alu", {6'h0, ALUControl}, 8'h0);
    tick();

    // Unknown cmd (0110): decodes as ADD, no writeback
    instr(4'b1110, 2'b00, 6'b001100);
    tick(); tick(); chk("unk_alu", {6'h0, ALUControl}, 8'h0);
    tick(); chk("unk_rw", {7'h0, RegWrite}, 8'h0);
    tick();

    // Undefined op: 0,1,0
    instr(4'b1110, 2'b11, 6'b000000);
    tick(); chk("und_s1", {4'h0, State}, 8'h1);
    tick(); chk("und_s0", {4'h0, State}, 8'h0);

    // Reset in MEMRD
    instr(4'b1110, 2'b01, 6'b011001);
    tick(); tick(); tick(); chk("mrst_s3", {4'h0, State}, 8'h3);
    reset = 1'b1; #1;
    chk("mrst_en", {4'h0, PCWrite, IRWrite, RegWrite, MemWrite}, 8'h0);
    tick(); chk("mrst_state", {4'h0, State}, 8'h0);
    chk("mrst_flags", {4'h0, Flags}, 8'h0);
    chk("mrst_en2", {4'h0, PCWrite, IRWrite, RegWrite, MemWrite}, 8'h0);
    reset = 1'b0;
    tick(); chk("mrst_s1", {4'h0, State}, 8'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
